fc_scheduler: RTL

Sequencer for the 120-neuron fully-connected layer (FC1, 400 inputs → 120 outputs). On `start` it clears the processing-element array, then streams each activation with its matching 120-lane weight word from the activation buffer and weight ROM, one pair per cycle. It then waits for the array's `finish`, holds the 1920-bit result until the downstream layer accepts it, and reports completion. It sits between the pooling-stage output buffer / weight ROM and the FC PE array.

---
 rtl/fc_scheduler_if.sv | 36 +++
 rtl/fc_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fc_scheduler_if.sv
// fc_scheduler_if
// Groups the FC1 sequencer's data-path signals: the shared read port toward
// the activation buffer / weight ROM, the PE array control and data lines,
// and the result valid/ready handshake toward the downstream layer.
//   rd_en, rd_addr : read strobe and address (scheduler -> buffer/ROM)
//   act_data       : activation read data, one cycle after rd_en
//   pe_clear       : accumulator clear pulse (scheduler -> PE array)
//   pe_ena         : multiply-accumulate enable (scheduler -> PE array)
//   pe_din         : activation forwarded to the PE array
//   pe_finish      : PE array completion (PE array -> scheduler)
//   res_valid      : results stable (scheduler -> downstream)
//   res_ready      : downstream accepts results (downstream -> scheduler)
interface fc_scheduler_if #(
  parameter int AW = 9,
  parameter int DW = 18
) ();
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] act_data;
  logic                 pe_clear;
  logic                 pe_ena;
  logic signed [DW-1:0] pe_din;
  logic                 pe_finish;
  logic                 res_valid;
  logic                 res_ready;

  modport master (
    output rd_en, rd_addr, pe_clear, pe_ena, pe_din, res_valid,
    input  act_data, pe_finish, res_ready
  );

  modport slave (
    input  rd_en, rd_addr, pe_clear, pe_ena, pe_din, res_valid,
    output act_data, pe_finish, res_ready
  );
endinterface

// File: rtl/fc_scheduler.sv
// fc_scheduler
// Sequencer for the 400-input / 120-output fully-connected layer. On start
// it clears the PE array, streams N_IN activation/weight pairs (one per
// cycle), waits for the array's finish (bounded by TIMEOUT), then holds the
// result until the downstream layer accepts it and pulses done.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : request one pass (only honoured in IDLE)
//   busy       : high whenever the sequencer is not idle
//   done       : one-cycle end-of-pass pulse (normal or error)
//   err        : sticky error, cleared by the next accepted start
//   bus        : read port, PE array control and result handshake
module fc_scheduler #(
  parameter int N_IN    = 400,
  parameter int AW      = 9,
  parameter int DW      = 18,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           err,
  fc_scheduler_if.master bus
);

  localparam int            TW        = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(N_IN - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t               state_r, state_next_s;
  logic [AW-1:0]        addr_r, addr_next_s;
  logic [TW-1:0]        tmo_r, tmo_next_s;
  logic                 done_r, done_next_s;
  logic                 err_r, err_next_s;
  logic                 busy_r, rd_en_r, pe_clear_r, pe_ena_r, res_valid_r;
  logic signed [DW-1:0] pe_din_s;

  // Next-state, counter and status decode.
  // The done pulse is issued one cycle before leaving WAIT/HOLD; done_r then
  // forces the exit, so busy stays high during the done cycle and the
  // following cycle is always a genuine IDLE cycle.
  always_comb begin
    state_next_s = state_r;
    addr_next_s  = addr_r;
    tmo_next_s   = {TW{1'b0}};
    done_next_s  = 1'b0;
    err_next_s   = err_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_next_s = S_CLR;
          err_next_s   = 1'b0;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_CLR: begin
        state_next_s = S_RUN;
        addr_next_s  = {AW{1'b0}};
        if (bus.pe_finish) begin
          err_next_s = 1'b1;
        end else begin
          err_next_s = err_r;
        end
      end
      S_RUN: begin
        if (bus.pe_finish) begin
          err_next_s = 1'b1;
        end else begin
          err_next_s = err_r;
        end
        // Terminal compare: the counter holds at N_IN-1 rather than wrapping.
        if (addr_r == ADDR_LAST) begin
          state_next_s = S_WAIT;
          addr_next_s  = addr_r;
        end else begin
          state_next_s = S_RUN;
          addr_next_s  = addr_r + AW'(1);
        end
      end
      S_WAIT: begin
        if (done_r) begin
          state_next_s = S_IDLE;
          tmo_next_s   = tmo_r;
        end else if (bus.pe_finish) begin
          state_next_s = S_HOLD;
        end else begin
          state_next_s = S_WAIT;
          if (tmo_r != TMO_MAX) begin
            tmo_next_s = tmo_r + TW'(1);
          end else begin
            tmo_next_s = tmo_r;
          end
          // Counter is about to reach TIMEOUT: flag the error and end the pass.
          if (tmo_r == TMO_LAST) begin
            done_next_s = 1'b1;
            err_next_s  = 1'b1;
          end else begin
            done_next_s = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (done_r) begin
          state_next_s = S_IDLE;
        end else if (bus.res_ready) begin
          state_next_s = S_HOLD;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = S_HOLD;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Counters and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r      <= {AW{1'b0}};
      tmo_r       <= {TW{1'b0}};
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      pe_clear_r  <= 1'b0;
      pe_ena_r    <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      addr_r      <= addr_next_s;
      tmo_r       <= tmo_next_s;
      done_r      <= done_next_s;
      err_r       <= err_next_s;
      busy_r      <= (state_next_s != S_IDLE);
      rd_en_r     <= (state_next_s == S_RUN);
      pe_clear_r  <= (state_next_s == S_CLR);
      // One-cycle delay lines pe_ena up with the buffer/ROM read latency.
      pe_ena_r    <= rd_en_r;
      res_valid_r <= (state_next_s == S_HOLD) && !done_next_s;
    end
  end

  assign pe_din_s      = bus.act_data;
  assign bus.pe_din    = pe_din_s;
  assign bus.rd_en     = rd_en_r;
  assign bus.rd_addr   = addr_r;
  assign bus.pe_clear  = pe_clear_r;
  assign bus.pe_ena    = pe_ena_r;
  assign bus.res_valid = res_valid_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;

endmodule
